// File: rtl/data_mem_responder_pkg.sv
// ============================================================================
//  Module   : mem (package)
//  Purpose  : Memory-bus access width encoding and byte-lane helpers shared by
//             the data RAM responder and the MMIO decoder.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package mem;

    typedef enum logic [1:0] {
        BYTE  = 2'b00,
        WORD  = 2'b01,
        DWORD = 2'b10
    } width_e;

    // Callers must have rejected misaligned accesses already.
    function automatic logic [3:0] lane_be(input logic [1:0] width, input logic [1:0] off);
        logic [3:0] be;
        case (width)
            BYTE:    be = 4'b0001 << off;
            WORD:    be = 4'b0011 << off;
            DWORD:   be = 4'hF;
            default: be = 4'h0;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [31:0] wd, input logic [1:0] width);
        logic [31:0] d;
        case (width)
            BYTE:    d = {4{wd[7:0]}};
            WORD:    d = {2{wd[15:0]}};
            default: d = wd;
        endcase
        return d;
    endfunction

    function automatic logic [31:0] lane_extract(input logic [31:0] word, input logic [1:0] width,
                                                 input logic [1:0] off);
        logic [31:0] sh_b;
        logic [31:0] sh_h;
        logic [31:0] d;
        sh_b = word >> {off, 3'b000};
        sh_h = word >> {off[1], 4'b0000};
        case (width)
            BYTE:    d = {24'h0, sh_b[7:0]};
            WORD:    d = {16'h0, sh_h[15:0]};
            default: d = word;
        endcase
        return d;
    endfunction

endpackage

`default_nettype wire

// File: rtl/data_mem_responder_bram_be.sv
// ============================================================================
//  Module   : bram_be
//  Purpose  : Single-port DEPTH x 32 RAM with per-byte write enable and a
//             READ_LATENCY-deep registered read pipeline.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module bram_be #(
    parameter int DEPTH        = 4096,
    parameter int READ_LATENCY = 2,
    parameter     INIT_FILE    = ""
) (
    input  logic                     i_clk,
    input  logic [3:0]               i_we,
    input  logic [$clog2(DEPTH)-1:0] i_addr,
    input  logic [31:0]              i_wdata,
    output logic [31:0]              o_rdata
);

    logic [31:0] ram [DEPTH];
    logic [31:0] rd_pipe_q [READ_LATENCY];

    always_ff @(posedge i_clk) begin
        for (int b = 0; b < 4; b++) begin
            if (i_we[b]) begin
                ram[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
            end
        end
        rd_pipe_q[0] <= ram[i_addr];
        for (int s = 1; s < READ_LATENCY; s++) begin
            rd_pipe_q[s] <= rd_pipe_q[s-1];
        end
    end

    assign o_rdata = rd_pipe_q[READ_LATENCY-1];

endmodule

`default_nettype wire

// File: rtl/data_mem_responder.sv
// ============================================================================
//  Module   : data_mem_responder
//  Purpose  : Memory-bus target serving CPU read/write pulses from a byte-
//             enabled data RAM; validates requests and zero-extends loads.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module data_mem_responder
    import mem::*;
#(
    parameter int          DEPTH        = 4096,
    parameter int          READ_LATENCY = 2,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter              INIT_FILE    = ""
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        dispatch_read,
    input  logic        dispatch_write,
    input  logic [31:0] addr,
    input  logic [1:0]  mem_width,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        busy,
    output logic        err_out
);

    localparam int          c_AW   = $clog2(DEPTH);
    localparam int          c_CW   = $clog2(READ_LATENCY + 1);
    localparam logic [32:0] c_SPAN = 33'(longint'(DEPTH) * 4);
    localparam logic [c_CW-1:0] c_RL = c_CW'(READ_LATENCY);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WRITE     = 2'd1,
        S_READ_WAIT = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [c_AW-1:0]   idx_q, idx_d;
    logic [1:0]        width_q, width_d;
    logic [1:0]        off_q, off_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [c_CW-1:0]   lat_cnt_q, lat_cnt_d;
    logic [31:0]       read_data_q, read_data_d;
    logic              err_q, err_d;

    logic [32:0]       w_rel;
    logic [c_AW-1:0]   w_idx;
    logic              w_req;
    logic              w_in_range;
    logic              w_width_ok;
    logic              w_aligned;
    logic              w_valid;
    logic [3:0]        w_ram_we;
    logic [c_AW-1:0]   w_ram_addr;
    logic [31:0]       w_ram_rdata;
    logic              w_unused_rel;

    // 33-bit difference so an address below BASE_ADDR wraps far above the span.
    assign w_rel        = {1'b0, addr} - {1'b0, BASE_ADDR};
    assign w_in_range   = (w_rel < c_SPAN);
    assign w_idx        = w_rel[c_AW+1:2];
    assign w_unused_rel = ^{w_rel[32:c_AW+2], w_rel[1:0]};

    assign w_req      = dispatch_read | dispatch_write;
    assign w_width_ok = (mem_width == BYTE) || (mem_width == WORD) || (mem_width == DWORD);
    assign w_aligned  = !(((mem_width == WORD) && addr[0]) ||
                          ((mem_width == DWORD) && (addr[1:0] != 2'b00)));
    assign w_valid    = w_in_range && w_width_ok && w_aligned && !(dispatch_read && dispatch_write);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        width_d     = width_q;
        off_d       = off_q;
        be_d        = be_q;
        wdata_d     = wdata_q;
        lat_cnt_d   = lat_cnt_q;
        read_data_d = read_data_q;
        err_d       = 1'b0;
        w_ram_we    = 4'h0;
        w_ram_addr  = idx_q;

        case (state_q)
            S_IDLE: begin
                w_ram_addr = w_idx;
                if (w_req) begin
                    if (w_valid) begin
                        idx_d   = w_idx;
                        width_d = mem_width;
                        off_d   = addr[1:0];
                        be_d    = lane_be(mem_width, addr[1:0]);
                        wdata_d = lane_wdata(write_data, mem_width);
                        if (dispatch_write) begin
                            state_d = S_WRITE;
                        end else begin
                            state_d   = S_READ_WAIT;
                            lat_cnt_d = c_CW'(1);
                        end
                    end else begin
                        err_d = 1'b1;
                        if (dispatch_read && !dispatch_write) begin
                            read_data_d = 32'h0;
                        end
                    end
                end
            end
            S_WRITE: begin
                w_ram_we = be_q;
                state_d  = S_IDLE;
                err_d    = w_req;
            end
            S_READ_WAIT: begin
                err_d = w_req;
                if (lat_cnt_q == c_RL) begin
                    read_data_d = lane_extract(w_ram_rdata, width_q, off_q);
                    state_d     = S_IDLE;
                end else begin
                    lat_cnt_d = lat_cnt_q + c_CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            width_q     <= 2'b00;
            off_q       <= 2'b00;
            be_q        <= 4'h0;
            wdata_q     <= 32'h0;
            lat_cnt_q   <= '0;
            read_data_q <= 32'h0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            width_q     <= width_d;
            off_q       <= off_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
            lat_cnt_q   <= lat_cnt_d;
            read_data_q <= read_data_d;
            err_q       <= err_d;
        end
    end

    bram_be #(
        .DEPTH        (DEPTH),
        .READ_LATENCY (READ_LATENCY),
        .INIT_FILE    (INIT_FILE)
    ) u_bram (
        .i_clk   (clk_in),
        .i_we    (w_ram_we),
        .i_addr  (w_ram_addr),
        .i_wdata (wdata_q),
        .o_rdata (w_ram_rdata)
    );

    assign busy      = w_req | (state_q != S_IDLE);
    assign read_data = read_data_q;
    assign err_out   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_data_mem_responder.sv
// ============================================================================
//  Module   : tb_data_mem_responder
//  Purpose  : Scoreboard bench for data_mem_responder: directed accesses with
//             hand-computed results, checked by an independent bus monitor.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_data_mem_responder;

    localparam int          RL    = 2;
    localparam int          DEPTH = 4096;
    localparam logic [1:0]  W_B   = 2'b00;
    localparam logic [1:0]  W_H   = 2'b01;
    localparam logic [1:0]  W_D   = 2'b10;
    localparam logic [1:0]  W_BAD = 2'b11;

    logic        clk_in;
    logic        rst_in;
    logic        dispatch_read;
    logic        dispatch_write;
    logic [31:0] addr;
    logic [1:0]  mem_width;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        busy;
    logic        err_out;

    data_mem_responder #(
        .DEPTH        (DEPTH),
        .READ_LATENCY (RL),
        .BASE_ADDR    (32'h0000_0000),
        .INIT_FILE    ("")
    ) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .dispatch_read  (dispatch_read),
        .dispatch_write (dispatch_write),
        .addr           (addr),
        .mem_width      (mem_width),
        .write_data     (write_data),
        .read_data      (read_data),
        .busy           (busy),
        .err_out        (err_out)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    typedef struct packed {
        logic        is_read;
        logic [7:0]  len;
        logic [31:0] data;
        logic [15:0] id;
    } cmp_t;

    typedef struct packed {
        logic        chk_rd;
        logic [31:0] rd;
        logic [15:0] id;
    } err_t;

    cmp_t cmp_q[$];
    err_t err_q[$];
    int   n_cmp  = 0;
    int   n_bad  = 0;
    int   tx_id  = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: error pulses pop the error queue, busy falling edges pop completions.
    logic prev_busy = 1'b0;
    int   blen      = 0;
    always @(negedge clk_in) begin
        cmp_t c;
        err_t e;
        if (rst_in) begin
            prev_busy = 1'b0;
            blen      = 0;
        end else begin
            if (err_out) begin
                n_cmp++;
                if (err_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_err_out: got 1, expected 0 (t=%0t)", $time);
                end else begin
                    e = err_q.pop_front();
                    if (e.chk_rd) check($sformatf("reject_read_data#%0d", e.id), read_data, e.rd);
                end
            end else if (prev_busy && !busy) begin
                n_cmp++;
                if (cmp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_completion: got busy fall, expected none (t=%0t)", $time);
                end else begin
                    c = cmp_q.pop_front();
                    check($sformatf("busy_len#%0d", c.id), 32'(blen), 32'(c.len));
                    if (c.is_read) check($sformatf("read_data#%0d", c.id), read_data, c.data);
                end
            end
            blen      = busy ? blen + 1 : 0;
            prev_busy = busy;
        end
    end

    task automatic drive(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [1:0] w, input logic [31:0] d);
        @(posedge clk_in); #1;
        dispatch_read  = rd;
        dispatch_write = wr;
        addr           = a;
        mem_width      = w;
        write_data     = d;
    endtask

    task automatic release_bus();
        @(posedge clk_in); #1;
        dispatch_read  = 1'b0;
        dispatch_write = 1'b0;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 50 && busy; k++) begin
            @(posedge clk_in); #1;
        end
        if (busy) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_idle_timeout: got busy=1, expected 0 (t=%0t)", $time);
        end
    endtask

    task automatic do_write(input logic [31:0] a, input logic [1:0] w, input logic [31:0] d);
        tx_id++;
        cmp_q.push_back('{is_read: 1'b0, len: 8'd2, data: 32'h0, id: 16'(tx_id)});
        drive(1'b0, 1'b1, a, w, d);
        release_bus();
        wait_idle();
    endtask

    task automatic do_read(input logic [31:0] a, input logic [1:0] w, input logic [31:0] exp);
        tx_id++;
        cmp_q.push_back('{is_read: 1'b1, len: 8'(1 + RL), data: exp, id: 16'(tx_id)});
        drive(1'b1, 1'b0, a, w, 32'h0);
        release_bus();
        wait_idle();
    endtask

    task automatic do_reject(input logic rd, input logic wr, input logic [31:0] a,
                             input logic [1:0] w, input logic [31:0] d, input logic chk);
        tx_id++;
        err_q.push_back('{chk_rd: chk, rd: 32'h0, id: 16'(tx_id)});
        drive(rd, wr, a, w, d);
        release_bus();
        wait_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_in         = 1'b1;
        dispatch_read  = 1'b0;
        dispatch_write = 1'b0;
        addr           = 32'h0;
        mem_width      = W_D;
        write_data     = 32'h0;
        repeat (3) @(posedge clk_in);
        #1 rst_in = 1'b0;
        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_read_data", read_data, 32'h0);
        check("reset_err_out", 32'(err_out), 32'd0);

        // Full-word round trip
        do_write(32'h100, W_D, 32'hDEAD_BEEF);
        do_read (32'h100, W_D, 32'hDEAD_BEEF);

        // Byte lanes; upper write_data bits must be ignored
        do_write(32'h200, W_B, 32'hAAAA_AA11);
        do_write(32'h201, W_B, 32'h5555_5522);
        do_write(32'h202, W_B, 32'hFFFF_FF33);
        do_write(32'h203, W_B, 32'h0000_0044);
        do_read (32'h200, W_D, 32'h4433_2211);
        do_read (32'h203, W_B, 32'h0000_0044);
        do_read (32'h201, W_B, 32'h0000_0022);

        // Halfword merge
        do_write(32'h300, W_D, 32'h1234_5678);
        do_write(32'h302, W_H, 32'h0000_ABCD);
        do_read (32'h300, W_D, 32'hABCD_5678);
        do_read (32'h302, W_H, 32'h0000_ABCD);
        do_read (32'h300, W_H, 32'h0000_5678);

        // Last valid word and word 0
        do_write(32'h3FFC, W_D, 32'hA5A5_5A5A);
        do_read (32'h3FFC, W_D, 32'hA5A5_5A5A);
        do_write(32'h0, W_D, 32'h0102_0304);

        // Rejections
        do_reject(1'b1, 1'b0, 32'h101,  W_D,   32'h0,          1'b1);
        do_reject(1'b0, 1'b1, 32'h103,  W_H,   32'h0000_7777,  1'b0);
        do_read  (32'h3FFC, W_D, 32'hA5A5_5A5A);
        do_reject(1'b1, 1'b0, 32'h4000, W_D,   32'h0,          1'b1);
        do_reject(1'b0, 1'b1, 32'h4000, W_D,   32'hFFFF_FFFF,  1'b0);
        do_read  (32'h100, W_D, 32'hDEAD_BEEF);
        do_reject(1'b1, 1'b0, 32'h100,  W_BAD, 32'h0,          1'b1);
        do_read  (32'h0,   W_D, 32'h0102_0304);
        do_read  (32'h100, W_D, 32'hDEAD_BEEF);

        // Write dispatched while a read is waiting on the RAM
        tx_id++;
        cmp_q.push_back('{is_read: 1'b1, len: 8'(1 + RL), data: 32'h4433_2211, id: 16'(tx_id)});
        tx_id++;
        err_q.push_back('{chk_rd: 1'b0, rd: 32'h0, id: 16'(tx_id)});
        drive(1'b1, 1'b0, 32'h200, W_D, 32'h0);
        drive(1'b0, 1'b1, 32'h200, W_D, 32'hFFFF_FFFF);
        release_bus();
        wait_idle();
        do_read(32'h200, W_D, 32'h4433_2211);

        // Simultaneous read and write
        do_reject(1'b1, 1'b1, 32'h100, W_D, 32'h0BAD_F00D, 1'b0);
        do_read  (32'h100, W_D, 32'hDEAD_BEEF);

        // Reset while a read is waiting
        drive(1'b1, 1'b0, 32'h100, W_D, 32'h0);
        release_bus();
        #1 rst_in = 1'b1;
        #1;
        check("rst_mid_read_busy", 32'(busy), 32'd0);
        check("rst_mid_read_read_data", read_data, 32'h0);
        @(posedge clk_in); #1 rst_in = 1'b0;

        // Reset during the WRITE cycle drops the store
        do_write(32'h400, W_D, 32'hCAFE_F00D);
        do_read (32'h400, W_D, 32'hCAFE_F00D);
        drive(1'b0, 1'b1, 32'h400, W_D, 32'h1212_1212);
        release_bus();
        #1 rst_in = 1'b1;
        #1;
        check("rst_mid_write_busy", 32'(busy), 32'd0);
        check("rst_mid_write_read_data", read_data, 32'h0);
        @(posedge clk_in); #1 rst_in = 1'b0;
        do_read(32'h400, W_D, 32'hCAFE_F00D);

        repeat (4) @(posedge clk_in);
        #1;
        check("pending_completions", 32'(cmp_q.size()), 32'd0);
        check("pending_errors", 32'(err_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
